// File: rtl/alu32_pkg.sv
// Shared definitions for the ALU operation sequencer: data width, opcodes
// and the sequencer FSM state encoding.
package alu32_pkg;

   localparam int DATA_W = 32;

   localparam logic [2:0] OP_AND   = 3'd0;
   localparam logic [2:0] OP_OR    = 3'd1;
   localparam logic [2:0] OP_XOR   = 3'd2;
   localparam logic [2:0] OP_NOT   = 3'd3;
   localparam logic [2:0] OP_ADD   = 3'd4;
   localparam logic [2:0] OP_LSH   = 3'd5;
   localparam logic [2:0] OP_RSH   = 3'd6;
   localparam logic [2:0] OP_TRUNC = 3'd7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Counter that sticks at all-ones; a synchronous clear has priority over
// an increment that lands on the same edge.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/alu32_op_sequencer.sv
// Drives the combinational 32-bit ALU one request at a time, holds its inputs
// for a settle window, captures and optionally checks the result.
module alu32_op_sequencer
   import alu32_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   // Request and response channels: a transfer happens on any rising edge
   // where valid and ready are both high; valid holds until that edge.
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_in1,
   input  logic [DATA_W-1:0] req_in2,
   input  logic              req_ci,
   input  logic [2:0]        req_op,
   input  logic              req_check,
   input  logic [DATA_W-1:0] req_expect,
   input  logic              req_expect_co,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic              alu_ci,
   output logic [2:0]        alu_a,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_co,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_co,
   output logic              rsp_match,
   input  logic              clear_counts,
   output logic [CNT_W-1:0]  op_count,
   output logic [CNT_W-1:0]  err_count
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   seq_state_t        r_state;
   logic [3:0]        r_settle_cnt;
   logic              r_check;
   logic [DATA_W-1:0] r_expect;
   logic              r_expect_co;

   logic w_req_hs;
   logic w_rsp_hs;
   logic w_match;
   logic w_err_inc;

   assign req_ready = (r_state == IDLE) && !rst;
   assign w_req_hs  = req_valid && req_ready;
   assign w_rsp_hs  = rsp_valid && rsp_ready;

   // Carry only carries meaning for ADD, so it is ignored for every other op.
   assign w_match   = !r_check ||
                      ((alu_out == r_expect) && ((alu_a != OP_ADD) || (alu_co == r_expect_co)));
   assign w_err_inc = w_rsp_hs && !rsp_match;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_settle_cnt <= '0;
         r_check      <= 1'b0;
         r_expect     <= '0;
         r_expect_co  <= 1'b0;
         alu_in1      <= '0;
         alu_in2      <= '0;
         alu_ci       <= 1'b0;
         alu_a        <= '0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         rsp_co       <= 1'b0;
         rsp_match    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req_hs) begin
                  alu_in1      <= req_in1;
                  alu_in2      <= req_in2;
                  alu_ci       <= req_ci;
                  alu_a        <= req_op;
                  r_check      <= req_check;
                  r_expect     <= req_expect;
                  r_expect_co  <= req_expect_co;
                  r_settle_cnt <= SETTLE_LOAD;
                  r_state      <= SETTLE;
               end
            end
            SETTLE: begin
               if (r_settle_cnt == 4'd0) begin
                  rsp_data  <= alu_out;
                  rsp_co    <= alu_co;
                  rsp_match <= w_match;
                  rsp_valid <= 1'b1;
                  r_state   <= RESP;
               end else begin
                  r_settle_cnt <= r_settle_cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_op_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_rsp_hs),
      .clr   (clear_counts),
      .count (op_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_err_inc),
      .clr   (clear_counts),
      .count (err_count)
   );

endmodule

// File: tb/tb_alu32_op_sequencer.sv
// Bench for alu32_op_sequencer: behavioural ALU stand-in, directed scenarios
// followed by randomized operations checked against a reference model.
module tb_alu32_op_sequencer;

   localparam int SC = 2;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [31:0]   req_in1 = '0;
   logic [31:0]   req_in2 = '0;
   logic          req_ci = 1'b0;
   logic [2:0]    req_op = '0;
   logic          req_check = 1'b0;
   logic [31:0]   req_expect = '0;
   logic          req_expect_co = 1'b0;
   logic [31:0]   alu_in1;
   logic [31:0]   alu_in2;
   logic          alu_ci;
   logic [2:0]    alu_a;
   logic [31:0]   alu_out;
   logic          alu_co;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [31:0]   rsp_data;
   logic          rsp_co;
   logic          rsp_match;
   logic          clear_counts = 1'b0;
   logic [CW-1:0] op_count;
   logic [CW-1:0] err_count;

   int checks = 0;
   int errors = 0;

   // {match, co, data} per accepted request
   logic [33:0] exp_q[$];
   int          m_ops  = 0;
   int          m_errs = 0;
   logic [31:0] l_in1;
   logic [31:0] l_in2;
   logic [2:0]  l_op;

   alu32_op_sequencer #(.SETTLE_CYCLES(SC), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_in1       (req_in1),
      .req_in2       (req_in2),
      .req_ci        (req_ci),
      .req_op        (req_op),
      .req_check     (req_check),
      .req_expect    (req_expect),
      .req_expect_co (req_expect_co),
      .alu_in1       (alu_in1),
      .alu_in2       (alu_in2),
      .alu_ci        (alu_ci),
      .alu_a         (alu_a),
      .alu_out       (alu_out),
      .alu_co        (alu_co),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_co        (rsp_co),
      .rsp_match     (rsp_match),
      .clear_counts  (clear_counts),
      .op_count      (op_count),
      .err_count     (err_count)
   );

   always #5 clk = ~clk;

   function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic ci, input logic [2:0] op);
      logic [32:0] r;
      case (op)
         3'd0:    r = {1'b0, a & b};
         3'd1:    r = {1'b0, a | b};
         3'd2:    r = {1'b0, a ^ b};
         3'd3:    r = {1'b0, ~a};
         3'd4:    r = {1'b0, a} + {1'b0, b} + {32'd0, ci};
         3'd5:    r = {1'b0, a << b[4:0]};
         3'd6:    r = {1'b0, a >> b[4:0]};
         default: r = {17'd0, a[15:0]};
      endcase
      return r;
   endfunction

   always_comb {alu_co, alu_out} = alu_ref(alu_in1, alu_in2, alu_ci, alu_a);

   function automatic int sat(input int v);
      return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_req(input logic [31:0] in1, input logic [31:0] in2, input logic ci,
                           input logic [2:0] op, input logic check,
                           input logic [31:0] expct, input logic exp_co);
      logic [32:0] r;
      logic        m;
      int          w;
      @(negedge clk);
      req_in1 = in1; req_in2 = in2; req_ci = ci; req_op = op;
      req_check = check; req_expect = expct; req_expect_co = exp_co;
      req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
      r = alu_ref(in1, in2, ci, op);
      m = !check || ((r[31:0] == expct) && ((op != 3'd4) || (r[32] == exp_co)));
      exp_q.push_back({m, r});
      l_in1 = in1; l_in2 = in2; l_op = op;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic recv_rsp(input int bp, input logic clr);
      logic [33:0] e;
      int          lat;
      lat = 0;
      @(negedge clk);
      while (!rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, SC);
      chk("queue_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      chk("rsp_data", rsp_data, e[31:0]);
      chk("rsp_co", {31'd0, rsp_co}, {31'd0, e[32]});
      chk("rsp_match", {31'd0, rsp_match}, {31'd0, e[33]});
      chk("alu_in1_held", alu_in1, l_in1);
      chk("alu_in2_held", alu_in2, l_in2);
      chk("alu_a_held", {29'd0, alu_a}, {29'd0, l_op});
      for (int i = 0; i < bp; i++) begin
         req_valid = 1'b1; req_in1 = $urandom; req_in2 = $urandom; req_op = 3'($urandom_range(0, 7));
         @(negedge clk);
         chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_rsp_data", rsp_data, e[31:0]);
         chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
         chk("bp_alu_in1", alu_in1, l_in1);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      clear_counts = clr;
      @(posedge clk);
      #1 rsp_ready = 1'b0; clear_counts = 1'b0;
      if (clr) begin
         m_ops = 0; m_errs = 0;
      end else begin
         m_ops = sat(m_ops);
         if (!e[33]) m_errs = sat(m_errs);
      end
      @(negedge clk);
      chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("post_req_ready", {31'd0, req_ready}, 32'd1);
      chk("op_count", {28'd0, op_count}, 32'(m_ops));
      chk("err_count", {28'd0, err_count}, 32'(m_errs));
   endtask

   task automatic do_op(input logic [31:0] in1, input logic [31:0] in2, input logic ci,
                        input logic [2:0] op, input logic check, input logic [31:0] expct,
                        input logic exp_co, input int bp, input logic clr);
      send_req(in1, in2, ci, op, check, expct, exp_co);
      recv_rsp(bp, clr);
   endtask

   task automatic do_reset_checks(input string tag);
      rst = 1'b1;
      #1;
      exp_q.delete();
      m_ops = 0; m_errs = 0;
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
      chk({tag, "_alu_in1"}, alu_in1, 32'd0);
      chk({tag, "_alu_a"}, {29'd0, alu_a}, 32'd0);
      chk({tag, "_rsp_data"}, rsp_data, 32'd0);
      chk({tag, "_op_count"}, {28'd0, op_count}, 32'd0);
      chk({tag, "_err_count"}, {28'd0, err_count}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [32:0] r;
      logic [31:0] in1, in2, ex;
      logic [2:0]  op;
      logic        ci;
      int          w;
      #2;
      do_reset_checks("reset");

      do_op(32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 3'd0, 1'b1, 32'hF000F000, 1'b0, 0, 1'b0);
      do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 3'd4, 1'b1, 32'h0, 1'b1, 0, 1'b0);
      do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 3'd4, 1'b1, 32'h0, 1'b0, 0, 1'b0);
      do_op(32'h12345678, 32'h0000FFFF, 1'b0, 3'd2, 1'b1, 32'h1234A987, 1'b1, 0, 1'b0);
      do_op(32'h0F0F0000, 32'h000000F0, 1'b1, 3'd1, 1'b0, 32'hDEADBEEF, 1'b0, 5, 1'b0);

      send_req(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 3'd1, 1'b1, 32'hFFFFFFFF, 1'b0);
      @(negedge clk);
      do_reset_checks("rst_settle");
      do_op(32'h0, 32'h0, 1'b0, 3'd3, 1'b1, 32'hFFFFFFFF, 1'b0, 0, 1'b0);

      send_req(32'h00000003, 32'h00000004, 1'b1, 3'd4, 1'b1, 32'h8, 1'b0);
      w = 0;
      while (!rsp_valid && w < 40) begin
         @(negedge clk);
         w++;
      end
      chk("resp_reached", {31'd0, rsp_valid}, 32'd1);
      do_reset_checks("rst_resp");

      for (int i = 0; i < 20; i++) begin
         in1 = $urandom; in2 = $urandom; ci = 1'($urandom_range(0, 1));
         op = 3'($urandom_range(0, 7));
         r = alu_ref(in1, in2, ci, op);
         ex = ($urandom_range(0, 2) == 0) ? (r[31:0] ^ (32'd1 << $urandom_range(0, 31))) : r[31:0];
         do_op(in1, in2, ci, op, 1'($urandom_range(0, 1)), ex, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), 1'b0);
      end
      chk("op_count_saturated", {28'd0, op_count}, 32'h0000000F);

      do_op(32'h1, 32'h2, 1'b0, 3'd4, 1'b1, 32'h7, 1'b1, 1, 1'b1);

      for (int i = 0; i < 6; i++) begin
         in1 = $urandom; in2 = $urandom; ci = 1'($urandom_range(0, 1));
         op = 3'($urandom_range(0, 7));
         r = alu_ref(in1, in2, ci, op);
         ex = ($urandom_range(0, 1) == 0) ? ~r[31:0] : r[31:0];
         do_op(in1, in2, ci, op, 1'b1, ex, r[32], $urandom_range(0, 2), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog observed=timeout expected=completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu32_op_sequencer.md
Name: alu32_op_sequencer

Overview:
- Synchronous initiator that drives the 32-bit gate-level ALU (operands In1/In2, carry CI, 3-bit op select A) and collects FinalOut/CO.
- Accepts one operation request at a time over valid/ready, holds the ALU inputs stable for a settle window, and registers the result.
- Returns the result over valid/ready and optionally compares it against an expected value, keeping operation and error counts.
- Sits between a command source (CPU datapath controller or hardware self-test engine) and the combinational ALU.

Parameters:
- SETTLE_CYCLES, 2, cycles the ALU inputs are held before the result is sampled; legal range 1..15.
- CNT_W, 16, width of the saturating op/error counters.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_in1  in  32  operand 1
- req_in2  in  32  operand 2
- req_ci  in  1  carry in
- req_op  in  3  ALU op select
- req_check  in  1  compare enable for this request
- req_expect  in  32  expected result
- req_expect_co  in  1  expected carry
- alu_in1  out  32  to ALU In1
- alu_in2  out  32  to ALU In2
- alu_ci  out  1  to ALU CI
- alu_a  out  3  to ALU A
- alu_out  in  32  from ALU FinalOut
- alu_co  in  1  from ALU CO
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  32  captured result
- rsp_co  out  1  captured carry
- rsp_match  out  1  1 = matched, or check disabled
- clear_counts  in  1  synchronous counter clear
- op_count  out  CNT_W  completed responses, saturating
- err_count  out  CNT_W  checked mismatches, saturating

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset values:
  - State is IDLE.
  - alu_*, rsp_data, rsp_co, rsp_match, rsp_valid, op_count and err_count are all 0.
  - req_ready is 0 while rst is high.
- req_ready = (state==IDLE) && !rst; it is registered-state derived and has no path from req_valid.
- FSM states:
  - IDLE: on the req_valid && req_ready edge, register operands, ci and op into alu_*, register check/expect, load settle_cnt = SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: alu_* held constant. When settle_cnt==0, sample alu_out/alu_co into rsp_data/rsp_co, compute rsp_match, set rsp_valid, go to RESP. Otherwise decrement settle_cnt.
  - RESP: rsp_valid=1 and rsp_* held stable. On rsp_valid && rsp_ready, clear rsp_valid and return to IDLE.
- Latency: a request accepted at edge N produces rsp_valid high after edge N+SETTLE_CYCLES. Throughput is at most one operation per SETTLE_CYCLES+2 cycles, with no overlap.
- alu_* keep their last values after completion; no toggling outside accept edges.
- Compare rule:
  - Data compare is rsp_data==expect.
  - CO is also compared only when op==ADD (4); for other ops CO is ignored.
  - When check=0, rsp_match=1.
- Counters, updated on the response handshake edge:
  - op_count += 1.
  - err_count += 1 if check && !match.
  - Both saturate at all-ones.
  - clear_counts zeroes both and wins over a coincident handshake increment.
- req_valid while not IDLE is ignored; the request is not consumed.
- rsp_ready while not RESP is ignored.
- Reset mid-operation: the pending operation is discarded, rsp_valid drops immediately (async), and the first request after reset release behaves normally.

Decomposition:
- Shared package alu32_pkg:
  - Opcode localparams: OP_AND=0, OP_OR=1, OP_XOR=2, OP_NOT=3, OP_ADD=4, OP_LSH=5, OP_RSH=6, OP_TRUNC=7.
  - FSM state encoding IDLE/SETTLE/RESP.
  - Data width 32.
- One sub-module, sat_counter (parameter CNT_W; inputs inc, clr), instantiated twice for op_count and err_count.

Test Plan:
- Reset, then op=0, in1=F0F0F0F0, in2=FF00FF00, ALU model returns F000F000, expect=F000F000, check=1 -> rsp_valid exactly 2 cycles after accept; rsp_data=F000F000, match=1; op_count=1, err_count=0.
- op=4, in1=FFFFFFFF, in2=00000001, ci=0, expect=0, expect_co=1 -> rsp_data=0, rsp_co=1, match=1. Repeat with expect_co=0 -> match=0, err_count=1.
- op=2, in1=12345678, in2=0000FFFF, expect=1234A987, expect_co mismatched -> match=1 (CO ignored for XOR); err_count unchanged.
- Backpressure: rsp_ready=0 for 5 cycles with req_valid=1 and new operands -> rsp_valid/rsp_data stable, req_ready=0, alu_* unchanged. After rsp_ready=1, req_ready=1 on the next cycle.
- Assert rst during SETTLE -> rsp_valid=0, alu_*=0, counts=0 immediately. A subsequent op=3, in1=0 request returns rsp_data=FFFFFFFF.
- CNT_W=4, 17 completed ops -> op_count=F (saturated). clear_counts on the same edge as the 18th handshake -> op_count=0, err_count=0.
